// File: rtl/pc_sequencer.sv
// Program counter sequencer: boot cycle, stall hold, jump/branch/jr redirects, exceptions, ERET and misaligned-target trapping.
// Optional MIPS delay-slot semantics when DELAY_SLOT_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic [31:0] epc,
  output logic        addr_err
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] SLOT = 2'd2;

  logic [1:0]  state, next_state;
  logic [31:0] next_pc, next_epc;
  logic        next_err;
  logic [31:0] jump_target, redir_target;
  logic        redir;

  assign pc_plus4    = pc + 32'd4;
  assign jump_target = {pc_plus4[31:28], instr_index, 2'b00};
  assign redir       = jr | jump | br_taken;
  assign redir_target = jr ? jr_target : (jump ? jump_target : br_target);
  assign pc_valid    = (state != BOOT);

`ifdef DELAY_SLOT_EN
  logic [31:0] pend, next_pend;
`endif

  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_epc   = epc;
    next_err   = 1'b0;
`ifdef DELAY_SLOT_EN
    next_pend  = pend;
`endif
    case (state)
      BOOT: next_state = RUN;
      RUN: begin
        if (exc_req) begin
          next_pc  = EXC_VECTOR;
          next_epc = pc;
        end else if (eret) begin
          // A corrupted EPC traps again rather than fetching from a bad address.
          if (epc[1:0] != 2'b00) begin
            next_pc  = EXC_VECTOR;
            next_err = 1'b1;
          end else begin
            next_pc = epc;
          end
        end else if (stall) begin
          next_pc = pc;
        end else if (redir) begin
`ifdef DELAY_SLOT_EN
          next_pend  = redir_target;
          next_pc    = pc_plus4;
          next_state = SLOT;
`else
          if (redir_target[1:0] != 2'b00) begin
            next_pc  = EXC_VECTOR;
            next_epc = redir_target;
            next_err = 1'b1;
          end else begin
            next_pc = redir_target;
          end
`endif
        end else begin
          next_pc = pc_plus4;
        end
      end
`ifdef DELAY_SLOT_EN
      SLOT: begin
        if (exc_req) begin
          // Restart at the branch itself so the delay slot re-executes after the handler.
          next_pc    = EXC_VECTOR;
          next_epc   = pc - 32'd4;
          next_state = RUN;
        end else if (!stall) begin
          next_state = RUN;
          if (pend[1:0] != 2'b00) begin
            next_pc  = EXC_VECTOR;
            next_epc = pend;
            next_err = 1'b1;
          end else begin
            next_pc = pend;
          end
        end
      end
`endif
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      epc      <= 32'd0;
      addr_err <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= next_pc;
      epc      <= next_epc;
      addr_err <= next_err;
    end
  end

`ifdef DELAY_SLOT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= 32'd0;
    else        pend <= next_pend;
  end
`endif

endmodule
